// File: rtl/jtag_scan_master.sv
// JTAG scan master: issues DR/IR scans and TAP resets from Run-Test/Idle,
// generating TCK at clk/2 and capturing TDO into rdata (bit 0 first).
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         cmd,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] wdata,
    input  logic               tdo,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [MAX_LEN-1:0] rdata
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {IDLE, SEL, CAPTURE, SHIFT, EXIT1, UPDATE, TRST, FINISH} state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic               phase, phase_nxt;
    logic               ir_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] wdata_q;
    logic               accept, bad_cmd, last_bit, in_bit;
    logic               tck_nxt, tms_nxt, tdi_nxt, busy_nxt, done_nxt, err_nxt;

    assign accept  = start && (state == IDLE);
    assign bad_cmd = (cmd == 2'b11) ||
                     (!cmd[1] && ((len == '0) || (len > LEN_W'(MAX_LEN))));

    always_comb begin
        last_bit = 1'b0;
        case (state)
            SEL:           last_bit = (cnt == LEN_W'(ir_q));
            CAPTURE:       last_bit = (cnt == LEN_W'(1));
            SHIFT:         last_bit = (cnt == len_q - LEN_W'(1));
            EXIT1, UPDATE: last_bit = 1'b1;
            TRST:          last_bit = (cnt == LEN_W'(5));
            default:       last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            phase <= 1'b0;
            tck   <= 1'b0;
            tms   <= 1'b1;
            tdi   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
            tck   <= tck_nxt;
            tms   <= tms_nxt;
            tdi   <= tdi_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // FINISH parks a rejected command for one cycle so err lands two clocks after start.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        phase_nxt = phase;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt   = '0;
                    phase_nxt = 1'b0;
                    if (bad_cmd)            state_nxt = FINISH;
                    else if (cmd == 2'b10)  state_nxt = TRST;
                    else                    state_nxt = SEL;
                end
            end
            FINISH: state_nxt = IDLE;
            default: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (last_bit) begin
                        cnt_nxt = '0;
                        case (state)
                            SEL:     state_nxt = CAPTURE;
                            CAPTURE: state_nxt = SHIFT;
                            SHIFT:   state_nxt = EXIT1;
                            EXIT1:   state_nxt = UPDATE;
                            default: state_nxt = IDLE;
                        endcase
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
        endcase
    end

    // Outputs are registered from the next state; tms/tdi only move when a new bit begins.
    always_comb begin
        in_bit   = (state_nxt != IDLE) && (state_nxt != FINISH);
        tck_nxt  = in_bit && phase_nxt;
        tms_nxt  = tms;
        tdi_nxt  = 1'b0;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state != IDLE) && (state_nxt == IDLE);
        err_nxt  = (state == FINISH);
        case (state_nxt)
            SEL:     tms_nxt = 1'b1;
            CAPTURE: tms_nxt = 1'b0;
            SHIFT: begin
                tms_nxt = (cnt_nxt == len_q - LEN_W'(1));
                tdi_nxt = wdata_q[cnt_nxt[IDX_W-1:0]];
            end
            EXIT1:   tms_nxt = 1'b1;
            UPDATE:  tms_nxt = 1'b0;
            TRST:    tms_nxt = (cnt_nxt < LEN_W'(5));
            default: tms_nxt = tms;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q    <= 1'b0;
            len_q   <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else if (accept) begin
            ir_q    <= cmd[0];
            len_q   <= len;
            wdata_q <= wdata;
            rdata   <= '0;
        end else if (state == SHIFT && !phase) begin
            rdata[cnt[IDX_W-1:0]] <= tdo;
        end
    end
endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: drives commands against a behavioural TAP
// target and compares TCK-bit streams, latency and captured data.
module tb_jtag_scan_master;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [LEN_W-1:0] len = '0;
    logic [31:0] wdata = '0;
    logic tdo, tck, tms, tdi, busy, done, err;
    logic [31:0] rdata;

    int n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .len(len), .wdata(wdata),
        .tdo(tdo), .tck(tck), .tms(tms), .tdi(tdi), .busy(busy), .done(done),
        .err(err), .rdata(rdata)
    );

    // Target TAP: standard 16-state controller with a chain of configurable length.
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t tap = TLR;
    logic [31:0] sr = '0, cap_dr = '0, cap_ir = '0, dr_upd = '0, ir_upd = '0;
    int chain = 32;
    logic tms_log[$];
    logic tdi_log[$];

    assign tdo = sr[0];

    function automatic tap_t next_tap(input tap_t s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    function automatic logic [31:0] mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    always @(posedge tck) begin
        tms_log.push_back(tms);
        tdi_log.push_back(tdi);
        case (tap)
            CAPDR:      sr <= cap_dr & mask(chain);
            CAPIR:      sr <= cap_ir & mask(chain);
            SHDR, SHIR: sr <= (sr >> 1) | (32'(tdi) << (chain - 1));
            UPDR:       dr_upd <= sr;
            UPIR:       ir_upd <= sr;
            TLR:        ir_upd <= '0;
            default: ;
        endcase
        tap <= next_tap(tap, tms);
    end

    // tms/tdi must hold while tck is high; done pulses are counted globally.
    logic ptms = 1'b1, ptdi = 1'b0;
    int glitch = 0, done_cnt = 0;
    always @(negedge clk) begin
        if (tck && (tms !== ptms || tdi !== ptdi)) glitch <= glitch + 1;
        ptms <= tms;
        ptdi <= tdi;
        if (done) done_cnt <= done_cnt + 1;
    end

    // Expected TMS/TDI per TCK bit, straight from the command's bit recipe.
    task automatic build_exp(input logic [1:0] c, input int l, input logic [31:0] w,
                             output logic [63:0] te, output logic [63:0] de, output int n);
        te = '0; de = '0; n = 0;
        if (c == 2'b10) begin
            for (int k = 0; k < 5; k++) begin te[n] = 1'b1; n++; end
            n++;
        end else begin
            te[n] = 1'b1; n++;
            if (c == 2'b01) begin te[n] = 1'b1; n++; end
            n += 2;
            for (int k = 0; k < l; k++) begin
                de[n] = w[k];
                te[n] = (k == l - 1);
                n++;
            end
            te[n] = 1'b1; n++;
            n++;
        end
    endtask

    task automatic pack_logs(output logic [63:0] tp, output logic [63:0] dp, output int n);
        tp = '0; dp = '0; n = tms_log.size();
        for (int i = 0; i < n && i < 64; i++) begin
            tp[i] = tms_log[i];
            dp[i] = tdi_log[i];
        end
    endtask

    logic err_d, busy_d;
    logic [31:0] rdata_d;

    task automatic run_cmd(input logic [1:0] c, input int l, input logic [31:0] w, output int lat);
        tms_log.delete();
        tdi_log.delete();
        @(negedge clk);
        cmd = c; len = LEN_W'(l); wdata = w; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i; err_d = err; busy_d = busy; rdata_d = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tck, tms, tdi, busy, done, err} !== 6'b010000)
            $display("FAIL reset_outputs got=%b exp=010000", {tck, tms, tdi, busy, done, err});
        else n_pass++;
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_tap_reset();
        int lat, n, ne;
        logic [63:0] tp, dp, te, de;
        tap = SHDR;
        run_cmd(2'b10, 0, 32'h0, lat);
        pack_logs(tp, dp, n);
        build_exp(2'b10, 0, 32'h0, te, de, ne);
        n_checks++;
        if (lat !== 13) $display("FAIL trst_latency got=%0d exp=13", lat); else n_pass++;
        n_checks++;
        if ({err_d, busy_d} !== 2'b00) $display("FAIL trst_err_busy got=%b exp=00", {err_d, busy_d});
        else n_pass++;
        n_checks++;
        if (n !== ne || tp !== te || dp !== de)
            $display("FAIL trst_bits got n=%0d tms=%h tdi=%h exp n=%0d tms=%h tdi=%h", n, tp, dp, ne, te, de);
        else n_pass++;
        n_checks++;
        if (tap !== RTI || rdata_d !== 32'h0)
            $display("FAIL trst_tap_state got tap=%0d rdata=%h exp tap=%0d rdata=0", tap, rdata_d, RTI);
        else n_pass++;
    endtask

    task automatic test_dr8();
        int lat, n, ne;
        logic [63:0] tp, dp, te, de;
        chain = 8; cap_dr = 32'h3C;
        run_cmd(2'b00, 8, 32'hA5, lat);
        pack_logs(tp, dp, n);
        build_exp(2'b00, 8, 32'hA5, te, de, ne);
        n_checks++;
        if (lat !== 27 || n !== 13) $display("FAIL dr8_timing got lat=%0d bits=%0d exp lat=27 bits=13", lat, n);
        else n_pass++;
        n_checks++;
        if (tp !== te || dp !== de)
            $display("FAIL dr8_bits got tms=%h tdi=%h exp tms=%h tdi=%h", tp, dp, te, de);
        else n_pass++;
        n_checks++;
        if (rdata_d !== 32'h3C) $display("FAIL dr8_rdata got=%h exp=3c", rdata_d); else n_pass++;
        n_checks++;
        if (dr_upd !== 32'hA5 || tap !== RTI)
            $display("FAIL dr8_target got upd=%h tap=%0d exp upd=a5 tap=%0d", dr_upd, tap, RTI);
        else n_pass++;
    endtask

    task automatic test_ir2();
        int lat, n, ne;
        logic [63:0] tp, dp, te, de;
        chain = 2; cap_ir = 32'h1;
        run_cmd(2'b01, 2, 32'h2, lat);
        pack_logs(tp, dp, n);
        build_exp(2'b01, 2, 32'h2, te, de, ne);
        n_checks++;
        if (n !== 8 || tp[7:0] !== 8'b0110_0011 || tp !== te)
            $display("FAIL ir2_tms got n=%0d tms=%h exp n=8 tms=%h", n, tp, te);
        else n_pass++;
        n_checks++;
        if (ir_upd !== 32'h2 || rdata_d !== 32'h1 || lat !== 17)
            $display("FAIL ir2_result got ir=%h rdata=%h lat=%0d exp ir=2 rdata=1 lat=17", ir_upd, rdata_d, lat);
        else n_pass++;
    endtask

    task automatic test_invalid();
        logic [1:0] cs[3] = '{2'b00, 2'b11, 2'b01};
        int ls[3] = '{0, 8, 33};
        int lat;
        for (int t = 0; t < 3; t++) begin
            run_cmd(cs[t], ls[t], 32'hFFFF_FFFF, lat);
            n_checks++;
            if (lat !== 2 || err_d !== 1'b1 || tms_log.size() !== 0 || rdata_d !== 32'h0)
                $display("FAIL invalid_%0d got lat=%0d err=%b tck_bits=%0d rdata=%h exp lat=2 err=1 tck_bits=0 rdata=0",
                         t, lat, err_d, tms_log.size(), rdata_d);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, n, ne, l, bad;
        logic [1:0] c;
        logic [31:0] w, cp, upd;
        logic [63:0] tp, dp, te, de;
        bad = 0;
        for (int it = 0; it < 16; it++) begin
            c = 2'($urandom_range(0, 1));
            l = $urandom_range(1, 32);
            w = $urandom; cp = $urandom;
            chain = l;
            if (c == 2'b00) cap_dr = cp; else cap_ir = cp;
            run_cmd(c, l, w, lat);
            pack_logs(tp, dp, n);
            build_exp(c, l, w, te, de, ne);
            upd = (c == 2'b00) ? dr_upd : ir_upd;
            n_checks++;
            if (lat !== 2 * ne + 1 || n !== ne || tp !== te || dp !== de)
                $display("FAIL rand_%0d_bits cmd=%0d len=%0d got lat=%0d n=%0d tms=%h tdi=%h exp lat=%0d n=%0d tms=%h tdi=%h",
                         it, c, l, lat, n, tp, dp, 2 * ne + 1, ne, te, de);
            else n_pass++;
            n_checks++;
            if (rdata_d !== (cp & mask(l)) || upd !== (w & mask(l)) || tap !== RTI)
                $display("FAIL rand_%0d_data cmd=%0d len=%0d got rdata=%h upd=%h tap=%0d exp rdata=%h upd=%h tap=%0d",
                         it, c, l, rdata_d, upd, tap, cp & mask(l), w & mask(l), RTI);
            else n_pass++;
        end
        n_checks++;
        if (glitch !== 0) $display("FAIL tms_tdi_stable_while_tck_high got=%0d exp=0", glitch);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, d0, lat2;
        chain = 32; cap_dr = 32'h1234_5678;
        tms_log.delete(); tdi_log.delete();
        @(negedge clk);
        cmd = 2'b00; len = LEN_W'(32); wdata = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        d0 = done_cnt;
        lat = 0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (i == 10) begin cmd = 2'b10; start = 1'b1; end
            if (i == 11) start = 1'b0;
            if (done) begin lat = i; rdata_d = rdata; break; end
        end
        n_checks++;
        if (lat !== 75 || tms_log.size() !== 37)
            $display("FAIL busy_ignore got lat=%0d bits=%0d exp lat=75 bits=37", lat, tms_log.size());
        else n_pass++;
        n_checks++;
        if (rdata_d !== 32'h1234_5678 || dr_upd !== 32'hFFFF_FFFF)
            $display("FAIL dr32_data got rdata=%h upd=%h exp rdata=12345678 upd=ffffffff", rdata_d, dr_upd);
        else n_pass++;
        // start raised in the done cycle itself
        cmd = 2'b10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat2 = 0;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_checks++;
                if (busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", busy); else n_pass++;
            end
            if (done) begin lat2 = i; break; end
        end
        @(negedge clk);
        n_checks++;
        if (lat2 !== 13 || done_cnt !== d0 + 2 || tap !== RTI)
            $display("FAIL b2b_accept got lat=%0d dones=%0d tap=%0d exp lat=13 dones=%0d tap=%0d",
                     lat2, done_cnt - d0, tap, d0 + 2 - d0, RTI);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0, lat;
        logic hit;
        chain = 8; cap_dr = 32'hFF;
        tms_log.delete(); tdi_log.delete();
        @(negedge clk);
        cmd = 2'b00; len = LEN_W'(8); wdata = 32'h5A; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        d0 = done_cnt;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (tms_log.size() == 7) begin hit = 1'b1; break; end
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (!hit || {tck, tms, tdi, busy, done, err} !== 6'b010000 || rdata !== 32'h0)
            $display("FAIL reset_mid_outputs reached=%b got=%b rdata=%h exp=010000 rdata=0",
                     hit, {tck, tms, tdi, busy, done, err}, rdata);
        else n_pass++;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (done_cnt !== d0) $display("FAIL reset_mid_no_done got=%0d exp=%0d", done_cnt, d0);
        else n_pass++;
        run_cmd(2'b10, 0, 32'h0, lat);
        n_checks++;
        if (lat !== 13 || tap !== RTI)
            $display("FAIL reset_mid_recover got lat=%0d tap=%0d exp lat=13 tap=%0d", lat, tap, RTI);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tap_reset();
        test_dr8();
        test_ir2();
        test_invalid();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
